// File: rtl/spi_device_fifo_pkg.sv
// Shared definitions for the SPI device with TX/RX FIFOs: state encoding,
// default fill word and a constant-width helper.
package spi_device_fifo_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Word shifted out when the TX FIFO runs dry (sliced down to WIDTH).
  localparam logic [31:0] TX_FILL_ONES = 32'hFFFF_FFFF;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_device_fifo_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port. Pointers carry
// one extra wrap bit so full and empty are distinguished by the MSB.
module sync_fifo
  import spi_device_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Pop on empty is dropped; push on full only lands when a pop frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; storage is cleared so the read port is 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spi_device_fifo.sv
// SPI device, all four CPOL/CPHA modes, with TX and RX FIFOs. SPI pins are
// oversampled by clk, so the whole block lives in one clock domain.
module spi_device_fifo
  import spi_device_fifo_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CPOL     = 0,
  parameter int               CPHA     = 0,
  parameter int               TX_DEPTH = 4,
  parameter int               RX_DEPTH = 4,
  parameter logic [WIDTH-1:0] TX_FILL  = TX_FILL_ONES[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_sdi,
  output logic             spi_sdo,
  output logic             spi_sdo_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overflow,
  output logic             tx_underrun,
  output logic             frame_abort
);

  localparam int   CW       = clog2(WIDTH);
  localparam logic IDLE_SCK = (CPOL != 0);
  localparam logic LATE_SMP = (CPHA != 0);

  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [2:0]       sck_q, cs_q;
  logic [1:0]       sdi_q;
  logic [0:0]       state;
  logic             active, sck_rise, sck_fall, lead_edge, trail_edge;
  logic             cs_fall, cs_rise, cs_evt, sample_edge, shift_edge;
  logic             do_sample, do_shift, rx_last, tx_last;
  logic             tx_load, tx_pop, tx_full, tx_empty, rx_full, rx_empty;
  logic             rx_push_q;
  logic [CW-1:0]    rx_cnt, tx_cnt;
  logic [WIDTH-1:0] rx_shift, tx_shift, tx_head;

  // Reset: asserts immediately, releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Pin synchronisers; the third sck/cs stage gives the previous synced value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= {3{IDLE_SCK}};
      cs_q  <= 3'b111;
      sdi_q <= 2'b00;
    end else begin
      sck_q <= {sck_q[1:0], spi_sck};
      cs_q  <= {cs_q[1:0], spi_cs_n};
      sdi_q <= {sdi_q[0], spi_sdi};
    end
  end

  assign sck_rise   = sck_q[1] & ~sck_q[2];
  assign sck_fall   = ~sck_q[1] & sck_q[2];
  assign lead_edge  = IDLE_SCK ? sck_fall : sck_rise;
  assign trail_edge = IDLE_SCK ? sck_rise : sck_fall;
  assign cs_fall    = cs_q[2] & ~cs_q[1];
  assign cs_rise    = ~cs_q[2] & cs_q[1];
  assign cs_evt     = cs_fall | cs_rise;

  assign sample_edge = LATE_SMP ? trail_edge : lead_edge;
  assign shift_edge  = LATE_SMP ? lead_edge : trail_edge;

  // A chip-select event in the same cycle masks any SCK edge.
  assign active    = (state == ST_ACTIVE);
  assign do_sample = active & ~cs_evt & sample_edge;
  assign do_shift  = active & ~cs_evt & shift_edge;

  assign rx_last = (rx_cnt == CW'(WIDTH - 1));
  assign tx_last = (tx_cnt == CW'(WIDTH - 1));

  // CPHA=0 preloads at select and reloads after the last bit's trailing
  // edge; CPHA=1 loads on the first leading edge of each word.
  assign tx_load = LATE_SMP ? (do_shift & (tx_cnt == '0))
                            : (cs_fall | (do_shift & tx_last));
  assign tx_pop  = tx_load & ~tx_empty;

  // Selection state follows the synchronised chip select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state <= ST_IDLE;
    else if (cs_fall) state <= ST_ACTIVE;
    else if (cs_rise) state <= ST_IDLE;
  end

  // Receive shifter; a completed word is pushed the cycle after its last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift    <= '0;
      rx_cnt      <= '0;
      rx_push_q   <= 1'b0;
      rx_overflow <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_push_q   <= do_sample & rx_last;
      rx_overflow <= rx_push_q & rx_full & ~rx_ready;
      frame_abort <= cs_rise & (rx_cnt != '0);
      if (cs_evt) begin
        rx_cnt <= '0;
      end else if (do_sample) begin
        rx_shift <= {rx_shift[WIDTH-2:0], sdi_q[1]};
        rx_cnt   <= rx_last ? '0 : rx_cnt + 1'b1;
      end
    end
  end

  // Transmit shifter; an empty FIFO at load time sends TX_FILL instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '0;
      tx_cnt      <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= tx_load & tx_empty;
      if (tx_load)       tx_shift <= tx_empty ? TX_FILL : tx_head;
      else if (do_shift) tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      if (cs_evt)        tx_cnt <= '0;
      else if (do_shift) tx_cnt <= tx_last ? '0 : tx_cnt + 1'b1;
    end
  end

  assign spi_sdo    = active & tx_shift[WIDTH-1];
  assign spi_sdo_oe = active;
  assign tx_ready   = ~tx_full;
  assign rx_valid   = ~rx_empty;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_valid), .wdata(tx_data),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // rx_shift holds the finished word during the push cycle.
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push_q), .wdata(rx_shift),
    .pop(rx_ready & rx_valid), .rdata(rx_data), .full(rx_full), .empty(rx_empty)
  );

endmodule

// File: tb/tb_spi_device_fifo.sv
// Bench for spi_device_fifo: four instances, one per SPI mode, driven by a
// common host model with per-mode clock polarity and capture edge.
module tb_spi_device_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sck;
  logic       cs_n, sdi, tx_valid, rx_ready;
  logic [7:0] tx_data;
  logic [3:0] sdo, sdo_oe, tx_ready, rx_valid, ovf, und, abt;
  logic [7:0] rx_data [4];

  int checks = 0;
  int failures = 0;

  int         und_c[4] = '{0, 0, 0, 0};
  int         ovf_c[4] = '{0, 0, 0, 0};
  int         abt_c[4] = '{0, 0, 0, 0};
  int         rx_n[4]  = '{0, 0, 0, 0};
  logic [7:0] rx_log [4][64];
  int         s_und[4], s_ovf[4], s_abt[4], s_rx[4];
  logic [7:0] mosi_w [8];
  logic [7:0] miso_w [4][8];

  typedef struct {
    string      name;
    int         nw;
    int         npush;
    logic [7:0] p0, p1, m0, m1;
    logic [7:0] sdo0, sdo1, rx0, rx1;
    int         und_cpha0, und_cpha1;
  } vec_t;
  vec_t tab[3];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      spi_device_fifo #(.WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .spi_sck(sck[g]), .spi_cs_n(cs_n), .spi_sdi(sdi),
        .spi_sdo(sdo[g]), .spi_sdo_oe(sdo_oe[g]), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
        .rx_ready(rx_ready), .rx_overflow(ovf[g]), .tx_underrun(und[g]),
        .frame_abort(abt[g])
      );
    end
  endgenerate

  // Pulse counters and RX pop log, sampled mid-cycle.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (und[m]) und_c[m]++;
      if (ovf[m]) ovf_c[m]++;
      if (abt[m]) abt_c[m]++;
      if (rx_valid[m] && rx_ready && rx_n[m] < 64) begin
        rx_log[m][rx_n[m]] = rx_data[m];
        rx_n[m]++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s mode%0d: got %0h expected %0h", nm, m, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_sck(input logic b);
    for (int m = 0; m < 4; m++) sck[m] = b ^ (m >= 2);
  endtask

  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic snap();
    for (int m = 0; m < 4; m++) begin
      s_und[m] = und_c[m];
      s_ovf[m] = ovf_c[m];
      s_abt[m] = abt_c[m];
      s_rx[m]  = rx_n[m];
    end
  endtask

  // Host: sdi set mid-phase and held across both edges of a bit, so the
  // leading-edge and trailing-edge samplers see the same value. MISO is
  // captured just before the host's own sample edge for each mode.
  task automatic frame(input int nbits, input bit end_cs);
    cs_n = 1'b0;
    wait_clk(6);
    for (int m = 0; m < 4; m++) chk("sdo_oe_selected", m, 32'(sdo_oe[m]), 32'd1);
    wait_clk(2);
    for (int b = 0; b < nbits; b++) begin
      int w, k;
      w = b / 8;
      k = 7 - (b % 8);
      wait_clk(4);
      sdi = mosi_w[w][k];
      wait_clk(4);
      for (int m = 0; m < 4; m++) if (m % 2 == 0) miso_w[m][w][k] = sdo[m];
      drive_sck(1'b1);
      wait_clk(8);
      for (int m = 0; m < 4; m++) if (m % 2 == 1) miso_w[m][w][k] = sdo[m];
      drive_sck(1'b0);
    end
    wait_clk(8);
    if (end_cs) begin
      cs_n = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int m = 0; m < 4; m++) begin
      chk({tag, "_sdo"}, m, 32'(sdo[m]), 32'd0);
      chk({tag, "_sdo_oe"}, m, 32'(sdo_oe[m]), 32'd0);
      chk({tag, "_tx_ready"}, m, 32'(tx_ready[m]), 32'd1);
      chk({tag, "_rx_valid"}, m, 32'(rx_valid[m]), 32'd0);
      chk({tag, "_rx_data"}, m, 32'(rx_data[m]), 32'd0);
      chk({tag, "_pulses"}, m, {29'd0, ovf[m], und[m], abt[m]}, 32'd0);
    end
  endtask

  initial begin
    tab[0] = '{"xfer_a5_3c", 2, 2, 8'hA5, 8'h3C, 8'h12, 8'h34, 8'hA5, 8'h3C, 8'h12, 8'h34, 1, 0};
    tab[1] = '{"xfer_81",    1, 1, 8'h81, 8'h00, 8'h81, 8'h00, 8'h81, 8'h00, 8'h81, 8'h00, 1, 0};
    tab[2] = '{"tx_empty",   2, 0, 8'h00, 8'h00, 8'h5A, 8'hC3, 8'hFF, 8'hFF, 8'h5A, 8'hC3, 3, 2};

    cs_n = 1'b1; sdi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
    drive_sck(1'b0);
    wait_clk(3);
    chk_reset_outputs("in_reset");
    reset_n = 1'b1;
    wait_clk(6);
    chk_reset_outputs("after_reset");

    // Table-driven exchanges, all four modes at once.
    for (int v = 0; v < 3; v++) begin
      snap();
      if (tab[v].npush > 0) push(tab[v].p0);
      if (tab[v].npush > 1) push(tab[v].p1);
      mosi_w[0] = tab[v].m0;
      mosi_w[1] = tab[v].m1;
      frame(tab[v].nw * 8, 1'b1);
      wait_clk(4);
      for (int m = 0; m < 4; m++) begin
        chk({tab[v].name, "_miso0"}, m, 32'(miso_w[m][0]), 32'(tab[v].sdo0));
        chk({tab[v].name, "_rx_cnt"}, m, rx_n[m] - s_rx[m], tab[v].nw);
        chk({tab[v].name, "_rx0"}, m, 32'(rx_log[m][s_rx[m]]), 32'(tab[v].rx0));
        if (tab[v].nw > 1) begin
          chk({tab[v].name, "_miso1"}, m, 32'(miso_w[m][1]), 32'(tab[v].sdo1));
          chk({tab[v].name, "_rx1"}, m, 32'(rx_log[m][s_rx[m] + 1]), 32'(tab[v].rx1));
        end
        chk({tab[v].name, "_underrun"}, m, und_c[m] - s_und[m],
            (m % 2 == 1) ? tab[v].und_cpha1 : tab[v].und_cpha0);
        chk({tab[v].name, "_overflow"}, m, ovf_c[m] - s_ovf[m], 0);
        chk({tab[v].name, "_abort"}, m, abt_c[m] - s_abt[m], 0);
        chk({tab[v].name, "_sdo_oe_idle"}, m, 32'(sdo_oe[m]), 32'd0);
      end
    end

    // RX full: five words with no pops, the fifth is dropped.
    rx_ready = 1'b0;
    snap();
    mosi_w[0] = 8'h11; mosi_w[1] = 8'h22; mosi_w[2] = 8'h33; mosi_w[3] = 8'h44; mosi_w[4] = 8'h55;
    frame(40, 1'b1);
    wait_clk(4);
    for (int m = 0; m < 4; m++) begin
      chk("ovf_pulses", m, ovf_c[m] - s_ovf[m], 1);
      chk("ovf_rx_valid_held", m, 32'(rx_valid[m]), 32'd1);
    end
    rx_ready = 1'b1;
    wait_clk(12);
    for (int m = 0; m < 4; m++) begin
      chk("ovf_rx_cnt", m, rx_n[m] - s_rx[m], 4);
      for (int w = 0; w < 4; w++)
        chk("ovf_rx_order", m, 32'(rx_log[m][s_rx[m] + w]), 32'(mosi_w[w]));
      chk("ovf_rx_drained", m, 32'(rx_valid[m]), 32'd0);
    end

    // Abort after three bits, then a clean frame.
    snap();
    mosi_w[0] = 8'hF0;
    frame(3, 1'b1);
    wait_clk(4);
    for (int m = 0; m < 4; m++) begin
      chk("abort_pulses", m, abt_c[m] - s_abt[m], 1);
      chk("abort_rx_cnt", m, rx_n[m] - s_rx[m], 0);
      chk("abort_rx_valid", m, 32'(rx_valid[m]), 32'd0);
    end
    snap();
    mosi_w[0] = 8'h55;
    frame(8, 1'b1);
    wait_clk(4);
    for (int m = 0; m < 4; m++) begin
      chk("post_abort_rx_cnt", m, rx_n[m] - s_rx[m], 1);
      chk("post_abort_rx", m, 32'(rx_log[m][s_rx[m]]), 32'h55);
      chk("post_abort_no_abort", m, abt_c[m] - s_abt[m], 0);
    end

    // Reset mid-frame with words queued in both FIFOs.
    rx_ready = 1'b0;
    mosi_w[0] = 8'h66; mosi_w[1] = 8'h77;
    frame(16, 1'b1);
    push(8'hAA);
    push(8'hBB);
    mosi_w[0] = 8'h9E;
    frame(5, 1'b0);
    for (int m = 0; m < 4; m++) chk("pre_reset_rx_valid", m, 32'(rx_valid[m]), 32'd1);
    reset_n = 1'b0;
    wait_clk(3);
    chk_reset_outputs("mid_frame_reset");
    cs_n = 1'b1;
    wait_clk(4);
    reset_n = 1'b1;
    rx_ready = 1'b1;
    wait_clk(6);
    snap();
    push(8'h3C);
    mosi_w[0] = 8'hC5;
    frame(8, 1'b1);
    wait_clk(4);
    for (int m = 0; m < 4; m++) begin
      chk("post_reset_miso", m, 32'(miso_w[m][0]), 32'h3C);
      chk("post_reset_rx_cnt", m, rx_n[m] - s_rx[m], 1);
      chk("post_reset_rx", m, 32'(rx_log[m][s_rx[m]]), 32'hC5);
      chk("post_reset_underrun", m, und_c[m] - s_und[m], (m % 2 == 1) ? 0 : 1);
      chk("post_reset_abort", m, abt_c[m] - s_abt[m], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
